// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the divider-subsystem counters.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade stage of a cascaded BCD down-counter.
// The stage steps only when the global decrement request is present and the
// stage below is borrowing; it wraps 0 -> 9 and passes the borrow upward.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       dec,
  input  logic       borrow_in,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  logic step;

  assign step       = dec & borrow_in;
  assign borrow_out = step & (digit == '0);

  // Digit register: reset, then load, then decrement with 0 -> 9 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (step) begin
      digit <= (digit == '0) ? BCD_MAX : (digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded multi-digit BCD down-counter / timer.
// One-shot mode holds at zero; auto-reload mode wraps zero back to the stored
// preset, giving a tick on o_tc every preset+1 enabled cycles.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_load,
  input  logic [BCD_W*NUM_DIGITS-1:0] i_load_val,
  input  logic                        i_en,
  output logic [BCD_W*NUM_DIGITS-1:0] o_count,
  output logic                        o_zero,
  output logic                        o_tc,
  output logic                        o_busy,
  output logic                        o_load_err
);

  localparam int   CW         = BCD_W * NUM_DIGITS;
  localparam logic AR_ENABLED = (AUTO_RELOAD != 0);

  logic [CW-1:0]       reload_q;
  logic                load_ok;
  logic                load_accept;
  logic                dec_req;
  logic                reload_req;
  logic                count_is_one;
  logic                digit_load;
  logic [CW-1:0]       digit_val;
  logic [NUM_DIGITS:0] borrow;
  logic                unused_top_borrow;
  logic                zero_d;
  logic                busy_d;
  logic                tc_d;
  logic                load_err_d;

  // Load is accepted only when every nibble of the preset is a decimal digit.
  always_comb begin
    load_ok = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!is_valid_bcd(i_load_val[d*BCD_W +: BCD_W])) load_ok = 1'b0;
    end
  end

  // Any load strobe (even a rejected one) pre-empts counting that cycle, so a
  // rejected load leaves the count untouched.
  assign load_accept  = i_load & load_ok;
  assign dec_req      = i_en & ~i_load & ~o_zero;
  assign reload_req   = AR_ENABLED & i_en & ~i_load & o_zero;
  assign count_is_one = (o_count == CW'(1));
  assign digit_load   = load_accept | reload_req;
  assign digit_val    = i_load ? i_load_val : reload_q;

  assign borrow[0]         = 1'b1;
  // Decrement is never requested at zero, so the top stage cannot borrow.
  assign unused_top_borrow = borrow[NUM_DIGITS];

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_down u_digit (
        .clk        (i_clk),
        .rst        (i_rst),
        .load       (digit_load),
        .load_val   (digit_val[g*BCD_W +: BCD_W]),
        .dec        (dec_req),
        .borrow_in  (borrow[g]),
        .digit      (o_count[g*BCD_W +: BCD_W]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // Next-state of the status flags, tracking what the digit chain will hold.
  always_comb begin
    zero_d     = o_zero;
    busy_d     = o_busy;
    tc_d       = dec_req & count_is_one;
    load_err_d = i_load & ~load_ok;
    if (load_accept) begin
      zero_d = (i_load_val == '0);
      busy_d = (i_load_val != '0);
    end else if (reload_req) begin
      zero_d = (reload_q == '0);
      busy_d = (reload_q != '0);
    end else if (dec_req && count_is_one) begin
      zero_d = 1'b1;
      busy_d = AR_ENABLED & (reload_q != '0);
    end
  end

  // Flag and reload registers; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      reload_q   <= '0;
      o_zero     <= 1'b1;
      o_busy     <= 1'b0;
      o_tc       <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      if (load_accept) reload_q <= i_load_val;
      o_zero     <= zero_d;
      o_busy     <= busy_d;
      o_tc       <= tc_d;
      o_load_err <= load_err_d;
    end
  end

endmodule
